// File: rtl/cond_flag_unit.sv
// cond_flag_unit: NZCV flags register, ARM condition evaluation and one-stage gated enable pipeline
module cond_flag_unit #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       cond,
   input  logic [1:0]       flag_write,
   input  logic [3:0]       alu_status,
   input  logic             reg_write_in,
   input  logic             mem_write_in,
   input  logic             pc_src_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             cond_ex,
   output logic             reg_write,
   output logic             mem_write,
   output logic             pc_src,
   output logic [3:0]       flags,
   output logic             carry_flag,
   output logic [CNT_W-1:0] squash_cnt
);
   logic             valid_q, valid_d, cex_q, cex_d, rw_q, rw_d, mw_q, mw_d, pc_q, pc_d;
   logic [3:0]       flags_q, flags_d;
   logic [CNT_W-1:0] sq_q, sq_d;
   logic             n, z, c, v, pass, hs_in;
   assign {n, z, c, v} = flags_q;
   assign in_ready = ~valid_q | out_ready;
   assign hs_in    = in_valid & in_ready;
   // Condition code evaluated against the flags as stored before this instruction's update
   always_comb begin
      pass = 1'b0;
      case (cond)
         4'h0: pass = z;
         4'h1: pass = ~z;
         4'h2: pass = c;
         4'h3: pass = ~c;
         4'h4: pass = n;
         4'h5: pass = ~n;
         4'h6: pass = v;
         4'h7: pass = ~v;
         4'h8: pass = c & ~z;
         4'h9: pass = ~c | z;
         4'hA: pass = n == v;
         4'hB: pass = n != v;
         4'hC: pass = ~z & (n == v);
         4'hD: pass = z | (n != v);
         4'hE: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end
   // Next state: accept loads the output stage and updates flags or the squash count; drain clears valid
   always_comb begin
      valid_d = valid_q;
      cex_d   = cex_q;
      rw_d    = rw_q;
      mw_d    = mw_q;
      pc_d    = pc_q;
      flags_d = flags_q;
      sq_d    = sq_q;
      if (hs_in) begin
         valid_d = 1'b1;
         cex_d   = pass;
         rw_d    = reg_write_in & pass;
         mw_d    = mem_write_in & pass;
         pc_d    = pc_src_in & pass;
         if (pass)
            flags_d = {flag_write[1] ? alu_status[1] : n,
                       flag_write[1] ? alu_status[3] : z,
                       flag_write[0] ? alu_status[2] : c,
                       flag_write[0] ? alu_status[0] : v};
         else if (sq_q != {CNT_W{1'b1}})
            sq_d = sq_q + 1'b1;
      end else if (out_ready)
         valid_d = 1'b0;
   end
   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         cex_q   <= 1'b0;
         rw_q    <= 1'b0;
         mw_q    <= 1'b0;
         pc_q    <= 1'b0;
         flags_q <= 4'b0000;
         sq_q    <= '0;
      end else begin
         valid_q <= valid_d;
         cex_q   <= cex_d;
         rw_q    <= rw_d;
         mw_q    <= mw_d;
         pc_q    <= pc_d;
         flags_q <= flags_d;
         sq_q    <= sq_d;
      end
   end
   assign out_valid  = valid_q;
   assign cond_ex    = cex_q;
   assign reg_write  = rw_q;
   assign mem_write  = mw_q;
   assign pc_src     = pc_q;
   assign flags      = flags_q;
   assign carry_flag = flags_q[1];
   assign squash_cnt = sq_q;
endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: directed self-checking bench for cond_flag_unit
module tb_cond_flag_unit;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [3:0]  cond = 4'h0, alu_status = 4'h0;
   logic [1:0]  flag_write = 2'b00;
   logic        reg_write_in = 1'b0, mem_write_in = 1'b0, pc_src_in = 1'b0;
   logic        in_ready, out_valid, cond_ex, reg_write, mem_write, pc_src, carry_flag;
   logic [3:0]  flags;
   logic [31:0] squash_cnt;
   logic        s_in_ready, s_out_valid, s_cond_ex, s_reg_write, s_mem_write, s_pc_src, s_carry;
   logic [3:0]  s_flags;
   logic [1:0]  s_squash;
   int          n_vec = 0, n_err = 0, exp_sq = 0;
   logic        e;

   always #5 clk = ~clk;

   cond_flag_unit u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .cond(cond),
      .flag_write(flag_write), .alu_status(alu_status), .reg_write_in(reg_write_in),
      .mem_write_in(mem_write_in), .pc_src_in(pc_src_in), .out_valid(out_valid),
      .out_ready(out_ready), .cond_ex(cond_ex), .reg_write(reg_write), .mem_write(mem_write),
      .pc_src(pc_src), .flags(flags), .carry_flag(carry_flag), .squash_cnt(squash_cnt));

   cond_flag_unit #(.CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .cond(cond),
      .flag_write(flag_write), .alu_status(alu_status), .reg_write_in(reg_write_in),
      .mem_write_in(mem_write_in), .pc_src_in(pc_src_in), .out_valid(s_out_valid),
      .out_ready(out_ready), .cond_ex(s_cond_ex), .reg_write(s_reg_write), .mem_write(s_mem_write),
      .pc_src(s_pc_src), .flags(s_flags), .carry_flag(s_carry), .squash_cnt(s_squash));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] st,
                        input logic rw, input logic mw, input logic pc);
      in_valid = 1'b1; cond = c; flag_write = fw; alu_status = st;
      reg_write_in = rw; mem_write_in = mw; pc_src_in = pc;
      @(posedge clk); #1;
   endtask

   function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
      logic b;
      case (c[3:1])
         3'd0: b = f[2];
         3'd1: b = f[1];
         3'd2: b = f[3];
         3'd3: b = f[0];
         3'd4: b = f[1] & ~f[2];
         3'd5: b = f[3] ~^ f[0];
         3'd6: b = ~f[2] & (f[3] ~^ f[0]);
         default: b = 1'b1;
      endcase
      return (c == 4'hF) ? 1'b0 : b ^ c[0];
   endfunction

   initial begin
      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_cond_ex", cond_ex, 0);
      chk("rst_flags", flags, 0);
      chk("rst_squash", squash_cnt, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      issue(4'hE, 2'b11, 4'b1000, 0, 0, 0);
      chk("al_out_valid", out_valid, 1);
      chk("al_cond_ex", cond_ex, 1);
      chk("al_flags", flags, 4'b0100);

      issue(4'h1, 2'b11, 4'b0000, 1, 1, 1);
      exp_sq = 1;
      chk("ne_cond_ex", cond_ex, 0);
      chk("ne_reg_write", reg_write, 0);
      chk("ne_mem_write", mem_write, 0);
      chk("ne_pc_src", pc_src, 0);
      chk("ne_flags", flags, 4'b0100);
      chk("ne_squash", squash_cnt, 1);

      for (int f = 0; f < 16; f++) begin
         logic [3:0] fv;
         fv = 4'(f);
         issue(4'hE, 2'b11, {fv[2], fv[1], fv[3], fv[0]}, 0, 0, 0);
         chk("sweep_flags", flags, fv);
         chk("sweep_carry", carry_flag, fv[1]);
         for (int c = 0; c < 16; c++) begin
            issue(4'(c), 2'b00, 4'hF, 1, 0, 1);
            e = exp_cond(4'(c), fv);
            if (!e) exp_sq++;
            chk($sformatf("cond_%0h_flags_%0h", c, f), cond_ex, e);
            chk("sweep_reg_write", reg_write, e);
            chk("sweep_pc_src", pc_src, e);
            chk("sweep_flags_hold", flags, fv);
         end
      end
      chk("sweep_squash", squash_cnt, exp_sq);

      issue(4'hE, 2'b11, 4'b0000, 1, 0, 0);
      chk("pre_stall_flags", flags, 0);
      out_ready = 1'b0;
      cond = 4'hE; flag_write = 2'b11; alu_status = 4'hF; reg_write_in = 1'b0;
      #1 chk("stall_in_ready", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("stall_in_ready_c", in_ready, 0);
         chk("stall_out_valid", out_valid, 1);
         chk("stall_reg_write", reg_write, 1);
         chk("stall_flags", flags, 0);
      end
      out_ready = 1'b1;
      #1 chk("release_in_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("release_flags", flags, 4'hF);
      chk("release_reg_write", reg_write, 0);
      chk("release_out_valid", out_valid, 1);
      chk("release_squash", squash_cnt, exp_sq);

      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("drain_out_valid", out_valid, 0);
      chk("drain_cond_ex_hold", cond_ex, 1);
      chk("drain_flags_hold", flags, 4'hF);
      chk("drain_in_ready", in_ready, 1);

      issue(4'hE, 2'b11, 4'b0000, 0, 0, 0);
      chk("b2b_clear_carry", carry_flag, 0);
      issue(4'hE, 2'b01, 4'b0100, 0, 0, 0);
      chk("b2b_op1_carry", carry_flag, 1);
      chk("b2b_op1_flags", flags, 4'b0010);
      issue(4'h2, 2'b00, 4'b0000, 1, 0, 0);
      chk("b2b_op2_cond_ex", cond_ex, 1);
      chk("b2b_op2_reg_write", reg_write, 1);
      issue(4'h3, 2'b00, 4'b0000, 1, 0, 0);
      chk("b2b_op3_cc_fail", cond_ex, 0);

      in_valid = 1'b0;
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      chk("rst2_squash", squash_cnt, 0);
      chk("rst2_sat_squash", s_squash, 0);
      for (int i = 0; i < 5; i++) issue(4'hF, 2'b11, 4'hF, 1, 1, 1);
      chk("sat_squash", s_squash, 2'b11);
      chk("wide_squash", squash_cnt, 5);
      chk("sat_flags", s_flags, 0);

      issue(4'hE, 2'b11, 4'hF, 1, 1, 1);
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk("mid_stall_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_cond_ex", cond_ex, 0);
      chk("mid_rst_reg_write", reg_write, 0);
      chk("mid_rst_mem_write", mem_write, 0);
      chk("mid_rst_pc_src", pc_src, 0);
      chk("mid_rst_flags", flags, 0);
      chk("mid_rst_carry", carry_flag, 0);
      chk("mid_rst_squash", squash_cnt, 0);
      chk("mid_rst_sat_valid", s_out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
